// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
//   Carries decoded control from ID through the EX, MEM and WB pipeline
//   registers. It also detects load-use hazards (one stall cycle plus a bubble),
//   squashes on a taken branch, and drives the ALU operand forwarding selects.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   id_*                      decoded control and register addresses of the ID instruction
//   ex_br_eq                  ALU equality result for the instruction in EX
//   pc_wen, ifid_wen          0 = hold PC / IF-ID (load-use stall)
//   ifid_flush                clear IF/ID on the next edge (taken branch)
//   ex_aluop, ex_alusrc       EX-stage ALU control
//   fwd_a, fwd_b              operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   br_taken                  branch in EX is taken, redirect PC
//   mem_read, mem_write       MEM-stage memory control
//   wb_wen, wb_memtoreg, wb_dst  WB-stage writeback control
//   stall_cnt, flush_cnt      saturating performance counters
//
// No handshakes: every register advances every cycle. The only exception is
// ID/EX, which loads a bubble instead of the ID instruction on a stall or a
// taken branch.
module ctrl_pipe_hazard #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_wen,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_alusrc,
  input  logic             id_memtoreg,
  input  logic             id_branch,
  input  logic [3:0]       id_aluop,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_dst,
  input  logic             ex_br_eq,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic [3:0]       ex_aluop,
  output logic             ex_alusrc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             br_taken,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_wen,
  output logic             wb_memtoreg,
  output logic [RA_W-1:0]  wb_dst,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            wen;
    logic            mem_read;
    logic            mem_write;
    logic            alusrc;
    logic            memtoreg;
    logic            branch;
    logic [3:0]      aluop;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] dst;
  } idex_t;

  typedef struct packed {
    logic            wen;
    logic            mem_read;
    logic            mem_write;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic            wen;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } memwb_t;

  idex_t  ex_q, id_in, ex_d;
  exmem_t mem_q;
  memwb_t wb_q;
  logic   hz, br, stall, flush;
  logic [CNT_W-1:0] stall_q, flush_q;

  // A bubble writes nothing. memtoreg=1 selects the ALU path, so nothing reads memory.
  function automatic idex_t bubble();
    idex_t b;
    b          = '0;
    b.memtoreg = 1'b1;
    return b;
  endfunction

  // EX/MEM is the newest producer, so it wins over MEM/WB. A load in MEM has
  // no data yet. The load-use stall guarantees that a load is only consumed
  // from WB.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
    logic [1:0] s;
    s = 2'b00;
    if (mem_q.wen && !mem_q.mem_read && mem_q.dst != '0 && mem_q.dst == src)
      s = 2'b10;
    else if (wb_q.wen && wb_q.dst != '0 && wb_q.dst == src)
      s = 2'b01;
    return s;
  endfunction

  always_comb begin
    id_in           = '0;
    id_in.wen       = id_wen;
    id_in.mem_read  = id_mem_read;
    id_in.mem_write = id_mem_write;
    id_in.alusrc    = id_alusrc;
    id_in.memtoreg  = id_memtoreg;
    id_in.branch    = id_branch;
    id_in.aluop     = id_aluop;
    id_in.rs        = id_rs;
    id_in.rt        = id_rt;
    id_in.dst       = id_dst;

    hz = ex_q.mem_read && ex_q.dst != '0 &&
         (ex_q.dst == id_rs || (id_uses_rt && ex_q.dst == id_rt));
    br = ex_q.branch && ex_br_eq;
    // A taken branch squashes the ID instruction anyway, so its hazard is moot.
    // While rst is high, hazard and branch decisions are suppressed.
    flush = !rst && br;
    stall = !rst && hz && !br;

    ex_d = (stall || flush) ? bubble() : id_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= bubble();
      mem_q   <= '{wen: 1'b0, mem_read: 1'b0, mem_write: 1'b0, memtoreg: 1'b1, dst: '0};
      wb_q    <= '{wen: 1'b0, memtoreg: 1'b1, dst: '0};
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      ex_q            <= ex_d;
      mem_q.wen       <= ex_q.wen;
      mem_q.mem_read  <= ex_q.mem_read;
      mem_q.mem_write <= ex_q.mem_write;
      mem_q.memtoreg  <= ex_q.memtoreg;
      mem_q.dst       <= ex_q.dst;
      wb_q.wen        <= mem_q.wen;
      wb_q.memtoreg   <= mem_q.memtoreg;
      wb_q.dst        <= mem_q.dst;
      if (stall && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign pc_wen      = !stall;
  assign ifid_wen    = !stall;
  assign ifid_flush  = flush;
  assign br_taken    = flush;
  assign ex_aluop    = ex_q.aluop;
  assign ex_alusrc   = ex_q.alusrc;
  assign fwd_a       = rst ? 2'b00 : fwd_sel(ex_q.rs);
  assign fwd_b       = rst ? 2'b00 : fwd_sel(ex_q.rt);
  assign mem_read    = mem_q.mem_read;
  assign mem_write   = mem_q.mem_write;
  assign wb_wen      = !rst && wb_q.wen;
  assign wb_memtoreg = wb_q.memtoreg;
  assign wb_dst      = wb_q.dst;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule
